region_box_detect: RTL and testbench

//  Upstream feeder of the bounding-box overlay stage. Scans the 1-bit fruit/colour mask
//  in raster order and grows up to 4 bounding boxes per frame. At each frame end it

---
 rtl/fruit_det_pkg.sv | 35 +++
 rtl/region_box_detect_if.sv | 10 +
 rtl/box_slot.sv | 51 +++++
 rtl/region_box_detect.sv | 180 ++++++++++++++++++
 tb/tb_region_box_detect.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fruit_det_pkg.sv
// Shared types for the region box detector: box slot record, committed edges and FSM states.
package fruit_det_pkg;

  localparam int unsigned CW      = 12;
  localparam int unsigned NUM_BOX = 4;

  typedef struct packed {
    logic          valid;
    logic [CW-1:0] l;
    logic [CW-1:0] r;
    logic [CW-1:0] t;
    logic [CW-1:0] b;
  } box_t;

  typedef struct packed {
    logic [CW-1:0] l;
    logic [CW-1:0] r;
    logic [CW-1:0] t;
    logic [CW-1:0] b;
  } edges_t;

  typedef enum logic [1:0] {StWait, StAccum, StCommit} state_e;

  // True when both box dimensions reach min_w; widths are formed at CW+1 bits.
  function automatic logic box_big_enough(box_t bx, int unsigned min_w);
    logic [CW:0] w;
    logic [CW:0] h;
    logic [CW:0] m;
    m = min_w[CW:0];
    w = {1'b0, bx.r} - {1'b0, bx.l} + {{CW{1'b0}}, 1'b1};
    h = {1'b0, bx.b} - {1'b0, bx.t} + {{CW{1'b0}}, 1'b1};
    return (w >= m) && (h >= m);
  endfunction

endpackage

// File: rtl/region_box_detect_if.sv
// Video mask input bundle: binary pixel plus raster timing.
interface region_box_detect_if;
  logic i_bin;
  logic i_hsync;
  logic i_vsync;
  logic i_de;

  modport master (output i_bin, output i_hsync, output i_vsync, output i_de);
  modport slave  (input  i_bin, input  i_hsync, input  i_vsync, input  i_de);
endinterface

// File: rtl/box_slot.sv
// One bounding-box slot: proximity hit test, load/extend/clear of a single box.
module box_slot
  import fruit_det_pkg::*;
#(
  parameter int unsigned MERGE = 8
) (
  input  logic          pixelclk,
  input  logic          reset_n,
  input  logic [CW-1:0] x,
  input  logic [CW-1:0] y,
  input  logic          ld,
  input  logic          ext,
  input  logic          clr,
  output logic          hit,
  output box_t          box
);

  localparam logic [CW:0] MergeW = MERGE[CW:0];

  box_t        box_q, box_d;
  logic [CW:0] xw, yw;

  assign xw  = {1'b0, x};
  assign yw  = {1'b0, y};
  assign box = box_q;

  // Raster order means y can never be above t, so only the bottom edge is tested.
  assign hit = box_q.valid &&
               (xw + MergeW >= {1'b0, box_q.l}) &&
               (xw <= {1'b0, box_q.r} + MergeW) &&
               (yw <= {1'b0, box_q.b} + MergeW);

  always_comb begin
    box_d = box_q;
    if (clr) begin
      box_d = '0;
    end else if (ld) begin
      box_d = '{valid: 1'b1, l: x, r: x, t: y, b: y};
    end else if (ext) begin
      if (x < box_q.l) box_d.l = x;
      if (x > box_q.r) box_d.r = x;
      if (y > box_q.b) box_d.b = y;
    end
  end

  always_ff @(posedge pixelclk) begin
    if (!reset_n) box_q <= '0;
    else          box_q <= box_d;
  end

endmodule

// File: rtl/region_box_detect.sv
// Grows up to four bounding boxes per frame from a binary mask and commits them at vsync.
// Define BOX_MIN_FILTER_EN to drop boxes narrower or shorter than MIN_W at commit.
module region_box_detect
  import fruit_det_pkg::*;
#(
  parameter int unsigned MERGE = 8,
  parameter int unsigned MIN_W = 16
) (
  input  logic              pixelclk,
  input  logic              reset_n,
  region_box_detect_if.slave vid,
  output logic [CW-1:0]     o_hcount,
  output logic [CW-1:0]     o_vcount,
  output logic [CW-1:0]     hcount_l1, hcount_l2, hcount_l3, hcount_l4,
  output logic [CW-1:0]     hcount_r1, hcount_r2, hcount_r3, hcount_r4,
  output logic [CW-1:0]     vcount_l1, vcount_l2, vcount_l3, vcount_l4,
  output logic [CW-1:0]     vcount_r1, vcount_r2, vcount_r3, vcount_r4,
  output logic [3:0]        number,
  output logic              overflow
);

`ifdef BOX_MIN_FILTER_EN
  localparam bit FilterEn = 1'b1;
`else
  localparam bit FilterEn = 1'b0;
`endif

  state_e                   state_q, state_d;
  logic [1:0]               idx_q, idx_d;
  logic                     de_q, vs_q, ovf_q;
  logic [CW-1:0]            h_cnt_q, v_cnt_q;
  logic [2:0]               pk_cnt_q, base, cnt_d;
  edges_t [NUM_BOX-1:0]     sh_q, sh_d, out_q;
  box_t                     slot_box [NUM_BOX];
  logic [NUM_BOX-1:0]       hit_vec, ext_vec, ld_vec;
  logic                     hit_any, free_any, drop, pix_ok, clr_all, keep;
  logic [1:0]               hit_idx, free_idx;
  logic                     vs_rise, de_fall;

  assign vs_rise = vid.i_vsync & ~vs_q;
  assign de_fall = ~vid.i_de & de_q;
  // A pixel coinciding with the frame-end edge belongs to no frame.
  assign pix_ok  = (state_q == StAccum) && !vs_rise && vid.i_de && vid.i_bin;

  always_ff @(posedge pixelclk) begin
    if (!reset_n) begin
      de_q     <= 1'b0;
      vs_q     <= 1'b0;
      h_cnt_q  <= '0;
      v_cnt_q  <= '0;
      o_hcount <= '0;
      o_vcount <= '0;
    end else begin
      de_q     <= vid.i_de;
      vs_q     <= vid.i_vsync;
      o_hcount <= h_cnt_q;
      o_vcount <= v_cnt_q;
      if (vid.i_de)   h_cnt_q <= h_cnt_q + 1'b1;
      else if (de_fall) h_cnt_q <= '0;
      if (vs_rise)      v_cnt_q <= '0;
      else if (de_fall) v_cnt_q <= v_cnt_q + 1'b1;
    end
  end

  for (genvar k = 0; k < NUM_BOX; k++) begin : g_slot
    box_slot #(.MERGE(MERGE)) u_slot (
      .pixelclk (pixelclk),
      .reset_n  (reset_n),
      .x        (h_cnt_q),
      .y        (v_cnt_q),
      .ld       (ld_vec[k]),
      .ext      (ext_vec[k]),
      .clr      (clr_all),
      .hit      (hit_vec[k]),
      .box      (slot_box[k])
    );
  end

  always_comb begin
    hit_any  = 1'b0;
    hit_idx  = '0;
    free_any = 1'b0;
    free_idx = '0;
    for (int k = NUM_BOX - 1; k >= 0; k--) begin
      if (hit_vec[k]) begin
        hit_any = 1'b1;
        hit_idx = 2'(k);
      end
      if (!slot_box[k].valid) begin
        free_any = 1'b1;
        free_idx = 2'(k);
      end
    end
    for (int k = 0; k < NUM_BOX; k++) begin
      ext_vec[k] = pix_ok && hit_any && (hit_idx == 2'(k));
      ld_vec[k]  = pix_ok && !hit_any && free_any && (free_idx == 2'(k));
    end
    drop = pix_ok && !hit_any && !free_any;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    clr_all = 1'b0;
    unique case (state_q)
      StWait:  if (vs_rise) state_d = StAccum;
      StAccum: begin
        if (vs_rise) begin
          state_d = StCommit;
          idx_d   = 2'd0;
        end
      end
      StCommit: begin
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          state_d = StAccum;
          clr_all = 1'b1;
        end
      end
      default: state_d = StWait;
    endcase
  end

  // Packer: slot idx_q is appended to the shadow list; the list restarts on slot 0.
  always_comb begin
    base = (idx_q == 2'd0) ? 3'd0 : pk_cnt_q;
    sh_d = (idx_q == 2'd0) ? '0 : sh_q;
    keep = slot_box[idx_q].valid && (!FilterEn || box_big_enough(slot_box[idx_q], MIN_W));
    if (keep) begin
      sh_d[base[1:0]] = '{l: slot_box[idx_q].l, r: slot_box[idx_q].r,
                          t: slot_box[idx_q].t, b: slot_box[idx_q].b};
    end
    cnt_d = base + {2'b00, keep};
  end

  always_ff @(posedge pixelclk) begin
    if (!reset_n) begin
      state_q  <= StWait;
      idx_q    <= '0;
      ovf_q    <= 1'b0;
      pk_cnt_q <= '0;
      sh_q     <= '0;
      out_q    <= '0;
      number   <= '0;
      overflow <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (clr_all)   ovf_q <= 1'b0;
      else if (drop) ovf_q <= 1'b1;
      if (state_q == StCommit) begin
        sh_q     <= sh_d;
        pk_cnt_q <= cnt_d;
        if (idx_q == 2'd3) begin
          out_q    <= sh_d;
          number   <= {1'b0, cnt_d};
          overflow <= ovf_q;
        end
      end
    end
  end

  assign hcount_l1 = out_q[0].l;
  assign hcount_l2 = out_q[1].l;
  assign hcount_l3 = out_q[2].l;
  assign hcount_l4 = out_q[3].l;
  assign hcount_r1 = out_q[0].r;
  assign hcount_r2 = out_q[1].r;
  assign hcount_r3 = out_q[2].r;
  assign hcount_r4 = out_q[3].r;
  assign vcount_l1 = out_q[0].t;
  assign vcount_l2 = out_q[1].t;
  assign vcount_l3 = out_q[2].t;
  assign vcount_l4 = out_q[3].t;
  assign vcount_r1 = out_q[0].b;
  assign vcount_r2 = out_q[1].b;
  assign vcount_r3 = out_q[2].b;
  assign vcount_r4 = out_q[3].b;

endmodule

// File: tb/tb_region_box_detect.sv
// Directed bench for region_box_detect: sparse raster frames built from rectangle lists.
module tb_region_box_detect;

  logic        pixelclk = 1'b0;
  logic        reset_n;
  logic [11:0] o_hcount, o_vcount;
  logic [11:0] hcount_l1, hcount_l2, hcount_l3, hcount_l4;
  logic [11:0] hcount_r1, hcount_r2, hcount_r3, hcount_r4;
  logic [11:0] vcount_l1, vcount_l2, vcount_l3, vcount_l4;
  logic [11:0] vcount_r1, vcount_r2, vcount_r3, vcount_r4;
  logic [3:0]  number;
  logic        overflow;

  int n_checks = 0;
  int n_errors = 0;

  int rx0 [8], rx1 [8], ry0 [8], ry1 [8];
  int n_rect;
  int exp_l [4], exp_r [4], exp_t [4], exp_b [4];
  int exp_n;
  int exp_ovf;

  region_box_detect_if vid ();

  region_box_detect dut (
    .pixelclk  (pixelclk),
    .reset_n   (reset_n),
    .vid       (vid),
    .o_hcount  (o_hcount),
    .o_vcount  (o_vcount),
    .hcount_l1 (hcount_l1), .hcount_l2 (hcount_l2), .hcount_l3 (hcount_l3), .hcount_l4 (hcount_l4),
    .hcount_r1 (hcount_r1), .hcount_r2 (hcount_r2), .hcount_r3 (hcount_r3), .hcount_r4 (hcount_r4),
    .vcount_l1 (vcount_l1), .vcount_l2 (vcount_l2), .vcount_l3 (vcount_l3), .vcount_l4 (vcount_l4),
    .vcount_r1 (vcount_r1), .vcount_r2 (vcount_r2), .vcount_r3 (vcount_r3), .vcount_r4 (vcount_r4),
    .number    (number),
    .overflow  (overflow)
  );

  always #5 pixelclk = ~pixelclk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge pixelclk);
      #1;
    end
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic clear_rects();
    n_rect = 0;
  endtask

  task automatic add_rect(input int x0, input int x1, input int y0, input int y1);
    rx0[n_rect] = x0; rx1[n_rect] = x1; ry0[n_rect] = y0; ry1[n_rect] = y1;
    n_rect++;
  endtask

  task automatic clear_exp();
    exp_n = 0;
    exp_ovf = 0;
    for (int k = 0; k < 4; k++) begin
      exp_l[k] = 0; exp_r[k] = 0; exp_t[k] = 0; exp_b[k] = 0;
    end
  endtask

  task automatic set_exp(input int k, input int l, input int r, input int t, input int b);
    exp_l[k] = l; exp_r[k] = r; exp_t[k] = t; exp_b[k] = b;
  endtask

  function automatic bit in_rect(input int x, input int y);
    for (int i = 0; i < n_rect; i++)
      if (x >= rx0[i] && x <= rx1[i] && y >= ry0[i] && y <= ry1[i]) return 1'b1;
    return 1'b0;
  endfunction

  // Each line is only as wide as its rightmost foreground pixel; lines outside all rects are 1 px.
  task automatic drive_line(input int y);
    int w;
    w = 1;
    for (int i = 0; i < n_rect; i++)
      if (y >= ry0[i] && y <= ry1[i] && rx1[i] + 1 > w) w = rx1[i] + 1;
    for (int x = 0; x < w; x++) begin
      vid.i_de  = 1'b1;
      vid.i_bin = in_rect(x, y);
      step(1);
    end
    vid.i_de  = 1'b0;
    vid.i_bin = 1'b0;
    step(4);
  endtask

  task automatic drive_frame();
    int h;
    h = 0;
    for (int i = 0; i < n_rect; i++) if (ry1[i] + 1 > h) h = ry1[i] + 1;
    for (int y = 0; y < h; y++) drive_line(y);
  endtask

  task automatic pulse_vsync();
    vid.i_vsync = 1'b1;
    step(3);
    vid.i_vsync = 1'b0;
    step(8);
  endtask

  task automatic check_outputs(input string tag);
    logic [11:0] gl [4], gr [4], gt [4], gb [4];
    gl = '{hcount_l1, hcount_l2, hcount_l3, hcount_l4};
    gr = '{hcount_r1, hcount_r2, hcount_r3, hcount_r4};
    gt = '{vcount_l1, vcount_l2, vcount_l3, vcount_l4};
    gb = '{vcount_r1, vcount_r2, vcount_r3, vcount_r4};
    check_eq($sformatf("%s.number", tag), 32'(number), 32'(exp_n));
    check_eq($sformatf("%s.overflow", tag), 32'(overflow), 32'(exp_ovf));
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("%s.l%0d", tag, k + 1), 32'(gl[k]), 32'(exp_l[k]));
      check_eq($sformatf("%s.r%0d", tag, k + 1), 32'(gr[k]), 32'(exp_r[k]));
      check_eq($sformatf("%s.t%0d", tag, k + 1), 32'(gt[k]), 32'(exp_t[k]));
      check_eq($sformatf("%s.b%0d", tag, k + 1), 32'(gb[k]), 32'(exp_b[k]));
    end
  endtask

  task automatic run_frame(input string tag);
    drive_frame();
    pulse_vsync();
    check_outputs(tag);
  endtask

  initial begin
    reset_n     = 1'b0;
    vid.i_bin   = 1'b0;
    vid.i_hsync = 1'b0;
    vid.i_vsync = 1'b0;
    vid.i_de    = 1'b0;
    clear_rects();
    clear_exp();
    step(3);
    check_outputs("reset");
    check_eq("reset.hcount", 32'(o_hcount), 32'd0);
    check_eq("reset.vcount", 32'(o_vcount), 32'd0);
    reset_n = 1'b1;
    step(2);

    // First vsync only leaves WAIT; partial frame content is never committed.
    add_rect(3, 3, 0, 0);
    run_frame("wait");

    // Raster counters on a frame with no foreground.
    clear_rects();
    for (int x = 0; x < 5; x++) begin
      vid.i_de = 1'b1;
      step(1);
    end
    check_eq("cnt.h4", 32'(o_hcount), 32'd4);
    check_eq("cnt.v0", 32'(o_vcount), 32'd0);
    vid.i_de = 1'b0;
    step(4);
    check_eq("cnt.hclr", 32'(o_hcount), 32'd0);
    for (int x = 0; x < 3; x++) begin
      vid.i_de = 1'b1;
      step(1);
    end
    check_eq("cnt.h2", 32'(o_hcount), 32'd2);
    check_eq("cnt.v1", 32'(o_vcount), 32'd1);
    vid.i_de = 1'b0;
    step(4);
    pulse_vsync();
    check_outputs("empty");

    clear_rects(); add_rect(100, 100, 50, 50);
    clear_exp(); exp_n = 1; set_exp(0, 100, 100, 50, 50);
    run_frame("single");

    clear_rects(); add_rect(200, 259, 100, 149);
    clear_exp(); exp_n = 1; set_exp(0, 200, 259, 100, 149);
    run_frame("solid");

    clear_rects();
    for (int i = 0; i < 5; i++) add_rect(20 * i, 20 * i + 1, 0, 1);
    clear_exp(); exp_n = 4; exp_ovf = 1;
    for (int i = 0; i < 4; i++) set_exp(i, 20 * i, 20 * i + 1, 0, 1);
    run_frame("five");

    clear_rects(); add_rect(300, 300, 10, 10); add_rect(305, 305, 12, 12);
    clear_exp(); exp_n = 1; set_exp(0, 300, 305, 10, 12);
    run_frame("merge");

    clear_rects(); add_rect(300, 300, 10, 10); add_rect(320, 320, 12, 12);
    clear_exp(); exp_n = 2; set_exp(0, 300, 300, 10, 10); set_exp(1, 320, 320, 12, 12);
    run_frame("split");

    clear_rects(); add_rect(10, 19, 0, 39); add_rect(100, 129, 0, 29);
    clear_exp();
`ifdef BOX_MIN_FILTER_EN
    exp_n = 1; set_exp(0, 100, 129, 0, 29);
`else
    exp_n = 2; set_exp(0, 10, 19, 0, 39); set_exp(1, 100, 129, 0, 29);
`endif
    run_frame("minw");

    // Reset mid-frame, then the first vsync only re-arms and the second one commits.
    clear_rects(); add_rect(10, 10, 1, 1);
    drive_line(0);
    drive_line(1);
    vid.i_de = 1'b1;
    step(2);
    reset_n  = 1'b0;
    step(2);
    vid.i_de = 1'b0;
    reset_n  = 1'b1;
    clear_exp();
    check_outputs("rst_mid");
    step(4);
    clear_rects(); add_rect(40, 40, 3, 3);
    run_frame("rst_wait");
    clear_rects(); add_rect(40, 41, 3, 4);
    clear_exp(); exp_n = 1; set_exp(0, 40, 41, 3, 4);
    run_frame("rst_commit");

    // Foreground on the vsync edge and during COMMIT must not reach any box.
    clear_rects(); add_rect(5, 5, 0, 0);
    drive_frame();
    vid.i_vsync = 1'b1;
    vid.i_de    = 1'b1;
    vid.i_bin   = 1'b1;
    step(4);
    vid.i_de    = 1'b0;
    vid.i_bin   = 1'b0;
    vid.i_vsync = 1'b0;
    step(8);
    clear_exp(); exp_n = 1; set_exp(0, 5, 5, 0, 0);
    check_outputs("edge");
    clear_rects();
    clear_exp();
    run_frame("after_edge");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
